// File: rtl/prio_enc_pkg.sv
// Shared definitions for the N-input priority encoder.
//   prio_enc_w()        : index width for an N-input encoder (never below 1)
//   PRIO_ENC_N_DEFAULT  : default request count
//   prio_enc_res_t      : encode result {idx, onehot, none, multi} for the default N;
//                         other N build the same layout with widths from prio_enc_w()
package prio_enc_pkg;

    localparam int unsigned PRIO_ENC_N_DEFAULT = 8;

    function automatic int unsigned prio_enc_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic [prio_enc_w(PRIO_ENC_N_DEFAULT)-1:0] idx;
        logic [PRIO_ENC_N_DEFAULT-1:0]             onehot;
        logic                                      none;
        logic                                      multi;
    } prio_enc_res_t;

endpackage

// File: rtl/prio_enc_rr_if.sv
// Request/result handshake bundle for prio_enc_rr.
//   in_valid/in_ready/in_req           : request vector channel
//   out_valid/out_ready/out_idx/
//   out_onehot/out_none/out_multi      : encoded result channel
// slave  : the encoder side; master : the producer/consumer side.
interface prio_enc_rr_if
    import prio_enc_pkg::*;
#(
    parameter int unsigned N = PRIO_ENC_N_DEFAULT
);
    localparam int unsigned W = prio_enc_w(N);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_req;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic [N-1:0] out_onehot;
    logic         out_none;
    logic         out_multi;

    modport slave (
        input  in_valid, in_req, out_ready,
        output in_ready, out_valid, out_idx, out_onehot, out_none, out_multi
    );

    modport master (
        output in_valid, in_req, out_ready,
        input  in_ready, out_valid, out_idx, out_onehot, out_none, out_multi
    );
endinterface

// File: rtl/prio_enc_core.sv
// Combinational encoder: descending search from ptr (wrapping below 0 to N-1),
// first set bit wins; multi when more than one request bit is set.
//   req : request vector     ptr : search start index (N-1 gives fixed priority)
//   res : {idx, onehot, none, multi}
module prio_enc_core
    import prio_enc_pkg::*;
#(
    parameter int unsigned N     = PRIO_ENC_N_DEFAULT,
    parameter type         res_t = prio_enc_res_t
) (
    input  logic [N-1:0]             req,
    input  logic [prio_enc_w(N)-1:0] ptr,
    output res_t                     res
);
    localparam int unsigned W = prio_enc_w(N);

    logic [W-1:0] sel;
    logic [W-1:0] pos;
    logic         found;
    int unsigned  cnt;

    always_comb begin
        sel   = '0;
        pos   = '0;
        found = 1'b0;
        cnt   = 0;
        // Visit in reverse search order so the last hit is the first in search order.
        for (int k = int'(N) - 1; k >= 0; k--) begin
            if (int'(ptr) >= k) pos = W'(int'(ptr) - k);
            else                pos = W'(int'(ptr) + int'(N) - k);
            if (req[pos]) begin
                sel   = pos;
                found = 1'b1;
            end
        end
        for (int i = 0; i < int'(N); i++) cnt = cnt + 32'(req[i]);
        res             = '0;
        res.idx         = sel;
        res.onehot[sel] = found;
        res.none        = !found;
        res.multi       = (cnt > 1);
    end
endmodule

// File: rtl/prio_enc_rr.sv
// Registered N-input priority encoder with valid/ready on both sides.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : prio_enc_rr_if.slave (request in, encoded result out)
// Build option: define PRIO_ENC_RR_EN for rotating priority; otherwise the
// highest set index always wins and no pointer is kept.
module prio_enc_rr
    import prio_enc_pkg::*;
#(
    parameter int unsigned N = PRIO_ENC_N_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    prio_enc_rr_if.slave  bus
);
    localparam int unsigned W = prio_enc_w(N);

    typedef struct packed {
        logic [W-1:0] idx;
        logic [N-1:0] onehot;
        logic         none;
        logic         multi;
    } res_t;

    res_t         res_c;
    res_t         res_q;
    logic         out_valid_q;
    logic         in_ready_c;
    logic         in_xfer_c;
    logic [W-1:0] ptr_c;

    // Only combinational path: out_ready -> in_ready.
    assign in_ready_c = !out_valid_q || bus.out_ready;
    assign in_xfer_c  = bus.in_valid && in_ready_c;

`ifdef PRIO_ENC_RR_EN
    logic [W-1:0] ptr_q;

    // Next search starts just below the last grant; an empty vector leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= W'(N - 1);
        end else if (in_xfer_c && !res_c.none) begin
            ptr_q <= (res_c.idx == '0) ? W'(N - 1) : res_c.idx - W'(1);
        end
    end

    assign ptr_c = ptr_q;
`else
    assign ptr_c = W'(N - 1);
`endif

    prio_enc_core #(
        .N     (N),
        .res_t (res_t)
    ) u_core (
        .req (bus.in_req),
        .ptr (ptr_c),
        .res (res_c)
    );

    // Output stage: load on input transfer, drop valid on a bare output transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
        end else if (in_xfer_c) begin
            out_valid_q <= 1'b1;
            res_q       <= res_c;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_idx    = res_q.idx;
    assign bus.out_onehot = res_q.onehot;
    assign bus.out_none   = res_q.none;
    assign bus.out_multi  = res_q.multi;
endmodule

// File: tb/tb_prio_enc_rr.sv
// Bench for prio_enc_rr: one N=8 and one N=5 instance, scoreboard of expected
// results, directed steps followed by random traffic with random backpressure.
module tb_prio_enc_rr;
    import prio_enc_pkg::*;

`ifdef PRIO_ENC_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic [2:0] idx;
        logic [7:0] oh;
        logic       none;
        logic       multi;
        int         dir;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vec = 0;
    int   errs = 0;
    exp_t sq [2][$];
    int   ptr_m [2];
    int   nsz [2] = '{8, 5};

    always #5 clk = ~clk;

    prio_enc_rr_if #(.N(8)) b8 ();
    prio_enc_rr_if #(.N(5)) b5 ();

    prio_enc_rr #(.N(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
    prio_enc_rr #(.N(5)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(b5.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference encoder: scan ptr, ptr-1, ... wrapping, first set bit wins.
    function automatic exp_t model(input int n, input logic [7:0] r, input int p,
                                   input int dir, output int np);
        exp_t e;
        int   g = -1;
        int   cnt = 0;
        for (int k = 0; k < n; k++) begin
            int q = (p - k + n) % n;
            if (g < 0 && r[q]) g = q;
        end
        for (int i = 0; i < n; i++) if (r[i]) cnt++;
        e.none  = (g < 0);
        e.idx   = (g < 0) ? 3'd0 : 3'(g);
        e.oh    = (g < 0) ? 8'd0 : (8'd1 << g);
        e.multi = (cnt > 1);
        e.dir   = dir;
        np      = (g < 0) ? p : ((g == 0) ? n - 1 : g - 1);
        return e;
    endfunction

    // One clock on instance s (0: N=8, 1: N=5); the other instance is idle and held.
    task automatic cyc(input int s, input logic v, input logic [7:0] req,
                       input logic rdy, input int dir);
        logic       ov, ir, nn, mu;
        logic [2:0] idx;
        logic [7:0] oh;
        logic       ev;
        exp_t       e;
        int         np;
        b8.in_valid  = (s == 0) && v;
        b8.in_req    = req;
        b8.out_ready = (s == 0) ? rdy : 1'b0;
        b5.in_valid  = (s == 1) && v;
        b5.in_req    = req[4:0];
        b5.out_ready = (s == 1) ? rdy : 1'b0;
        #1;
        if (s == 0) begin
            ov = b8.out_valid; ir = b8.in_ready; idx = b8.out_idx;
            oh = b8.out_onehot; nn = b8.out_none; mu = b8.out_multi;
        end else begin
            ov = b5.out_valid; ir = b5.in_ready; idx = b5.out_idx;
            oh = 8'(b5.out_onehot); nn = b5.out_none; mu = b5.out_multi;
        end
        ev = (sq[s].size() != 0);
        chk("out_valid", 32'(ov), 32'(ev));
        chk("in_ready", 32'(ir), 32'(!ev || rdy));
        if (ev) begin
            e = sq[s][0];
            chk("result", {19'd0, idx, oh, nn, mu}, {19'd0, e.idx, e.oh, e.none, e.multi});
            if (e.dir >= 0) chk("directed_idx", 32'(idx), 32'(e.dir));
            if (rdy) void'(sq[s].pop_front());
        end
        if (v && (!ev || rdy)) begin
            e = model(nsz[s], req, RR ? ptr_m[s] : nsz[s] - 1, dir, np);
            if (RR) ptr_m[s] = np;
            sq[s].push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset();
        chk("rst_valid8", 32'(b8.out_valid), 32'd0);
        chk("rst_fields8", {19'd0, b8.out_idx, b8.out_onehot, b8.out_none, b8.out_multi}, 32'd0);
        chk("rst_ready8", 32'(b8.in_ready), 32'd1);
        chk("rst_valid5", 32'(b5.out_valid), 32'd0);
        chk("rst_fields5", {22'd0, b5.out_idx, b5.out_onehot, b5.out_none, b5.out_multi}, 32'd0);
        chk("rst_ready5", 32'(b5.in_ready), 32'd1);
        sq[0].delete();
        sq[1].delete();
        ptr_m[0] = 7;
        ptr_m[1] = 4;
    endtask

    initial begin
        b8.in_valid = 1'b0; b8.in_req = '0; b8.out_ready = 1'b0;
        b5.in_valid = 1'b0; b5.in_req = '0; b5.out_ready = 1'b0;
        #1;
        chk_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Backpressure: result 3 held while in_req churns, then accept on release.
        cyc(0, 1'b1, 8'h0A, 1'b1, 3);
        cyc(0, 1'b1, 8'hF0, 1'b0, -1);
        cyc(0, 1'b1, 8'h55, 1'b0, -1);
        cyc(0, 1'b1, 8'hAA, 1'b0, -1);
        cyc(0, 1'b1, 8'hFF, 1'b0, -1);
        cyc(0, 1'b1, 8'h26, 1'b1, RR ? 2 : 5);
        cyc(0, 1'b1, 8'h00, 1'b1, 0);
        cyc(0, 1'b0, 8'h00, 1'b1, -1);

        // Asynchronous reset while a result is pending.
        cyc(0, 1'b1, 8'h3C, 1'b1, -1);
        b8.out_ready = 1'b0; b5.out_ready = 1'b0;
        b8.in_valid  = 1'b0; b5.in_valid  = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back full vectors, then wrap of the search start.
        cyc(0, 1'b1, 8'hFF, 1'b1, 7);
        cyc(0, 1'b1, 8'hFF, 1'b1, RR ? 6 : 7);
        cyc(0, 1'b1, 8'hFF, 1'b1, RR ? 5 : 7);
        cyc(0, 1'b1, 8'hFF, 1'b1, RR ? 4 : 7);
        cyc(0, 1'b1, 8'h81, 1'b1, RR ? 0 : 7);
        cyc(0, 1'b1, 8'h81, 1'b1, 7);
        cyc(0, 1'b0, 8'h00, 1'b1, -1);

        // Non-power-of-2 width.
        cyc(1, 1'b1, 8'h10, 1'b1, 4);
        cyc(1, 1'b1, 8'h01, 1'b1, 0);
        cyc(1, 1'b1, 8'h1F, 1'b1, 4);
        cyc(1, 1'b1, 8'h06, 1'b1, RR ? 2 : 2);
        cyc(1, 1'b0, 8'h00, 1'b1, -1);

        // Random traffic with random backpressure on both widths.
        for (int i = 0; i < 60; i++)
            cyc(0, 1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0), -1);
        cyc(0, 1'b0, 8'h00, 1'b1, -1);
        cyc(0, 1'b0, 8'h00, 1'b1, -1);
        for (int i = 0; i < 60; i++)
            cyc(1, 1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0), -1);
        cyc(1, 1'b0, 8'h00, 1'b1, -1);
        cyc(1, 1'b0, 8'h00, 1'b1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
